// File: rtl/ctrl_pkg.sv
// Shared opcodes, ALU/PC/writeback encodings and FSM state for pipe_ctrl_unit.
package ctrl_pkg;

  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned DIV_CNT_W = 6;

  localparam logic [6:0] OP_R    = 7'h33;
  localparam logic [6:0] OP_I    = 7'h13;
  localparam logic [6:0] OP_LUI  = 7'h37;
  localparam logic [6:0] OP_SYS  = 7'h73;
  localparam logic [6:0] OP_JAL  = 7'h6F;
  localparam logic [6:0] OP_JALR = 7'h67;
  localparam logic [6:0] OP_BR   = 7'h63;

  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

  localparam logic [11:0] CSR_GPIO_IN  = 12'hf00;
  localparam logic [11:0] CSR_GPIO_OUT = 12'hf02;

  typedef enum logic [4:0] {
    ALU_AND   = 5'b00000,
    ALU_OR    = 5'b00001,
    ALU_XOR   = 5'b00010,
    ALU_ADD   = 5'b00011,
    ALU_SUB   = 5'b00100,
    ALU_MUL   = 5'b00101,
    ALU_MULH  = 5'b00110,
    ALU_MULHU = 5'b00111,
    ALU_SLL   = 5'b01000,
    ALU_SRL   = 5'b01001,
    ALU_SRA   = 5'b01010,
    ALU_SLT   = 5'b01100,
    ALU_SLTU  = 5'b01101,
    ALU_DIV   = 5'b10000,
    ALU_DIVU  = 5'b10001,
    ALU_REM   = 5'b10010,
    ALU_REMU  = 5'b10011
  } aluop_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_JALR   = 2'b01,
    PC_JAL    = 2'b10,
    PC_BRANCH = 2'b11
  } pcsrc_e;

  typedef enum logic [1:0] {
    RS_GPIO = 2'b00,
    RS_LUI  = 2'b01,
    RS_ALU  = 2'b10,
    RS_PC4  = 2'b11
  } regsel_e;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_DIV_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/instructionDecoder.sv
// Combinational RV32 control decoder for the instruction held in EX.
// Optional divide/remainder decode under CTRL_MULDIV_EN.
module instructionDecoder
  import ctrl_pkg::*;
(
`ifdef CTRL_MULDIV_EN
  output logic        o_is_div,
`endif
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [11:0] i_imm12,
  output aluop_e      o_aluop,
  output logic        o_alusrc,
  output regsel_e     o_regsel,
  output logic        o_regwrite,
  output logic        o_gpio_we,
  output logic        o_jal,
  output logic        o_jalr,
  output logic        o_branch,
  output logic        o_illegal
);

  logic [6:0] w_funct7;
  assign w_funct7 = i_imm12[11:5];

  // Decode opcode/funct fields; any unlisted encoding is illegal and side-effect free.
  always_comb begin
    o_aluop    = ALU_ADD;
    o_alusrc   = 1'b0;
    o_regsel   = RS_ALU;
    o_regwrite = 1'b0;
    o_gpio_we  = 1'b0;
    o_jal      = 1'b0;
    o_jalr     = 1'b0;
    o_branch   = 1'b0;
    o_illegal  = 1'b0;
`ifdef CTRL_MULDIV_EN
    o_is_div   = 1'b0;
`endif
    case (i_opcode)
      OP_R: begin
        o_regwrite = 1'b1;
        case (w_funct7)
          7'b0000000: begin
            case (i_funct3)
              3'b000:  o_aluop = ALU_ADD;
              3'b001:  o_aluop = ALU_SLL;
              3'b010:  o_aluop = ALU_SLT;
              3'b011:  o_aluop = ALU_SLTU;
              3'b100:  o_aluop = ALU_XOR;
              3'b101:  o_aluop = ALU_SRL;
              3'b110:  o_aluop = ALU_OR;
              default: o_aluop = ALU_AND;
            endcase
          end
          7'b0100000: begin
            case (i_funct3)
              3'b000:  o_aluop = ALU_SUB;
              3'b101:  o_aluop = ALU_SRA;
              default: o_illegal = 1'b1;
            endcase
          end
          7'b0000001: begin
            case (i_funct3)
              3'b000:  o_aluop = ALU_MUL;
              3'b001:  o_aluop = ALU_MULH;
              3'b011:  o_aluop = ALU_MULHU;
`ifdef CTRL_MULDIV_EN
              3'b100:  begin o_aluop = ALU_DIV;  o_is_div = 1'b1; end
              3'b101:  begin o_aluop = ALU_DIVU; o_is_div = 1'b1; end
              3'b110:  begin o_aluop = ALU_REM;  o_is_div = 1'b1; end
              3'b111:  begin o_aluop = ALU_REMU; o_is_div = 1'b1; end
`endif
              default: o_illegal = 1'b1;
            endcase
          end
          default: o_illegal = 1'b1;
        endcase
      end
      OP_I: begin
        o_regwrite = 1'b1;
        o_alusrc   = 1'b1;
        case (i_funct3)
          3'b000: o_aluop = ALU_ADD;
          3'b010: o_aluop = ALU_SLT;
          3'b011: o_aluop = ALU_SLTU;
          3'b100: o_aluop = ALU_XOR;
          3'b110: o_aluop = ALU_OR;
          3'b111: o_aluop = ALU_AND;
          3'b001: begin
            if (w_funct7 == 7'b0000000) o_aluop = ALU_SLL;
            else                        o_illegal = 1'b1;
          end
          default: begin
            if (w_funct7 == 7'b0000000)      o_aluop = ALU_SRL;
            else if (w_funct7 == 7'b0100000) o_aluop = ALU_SRA;
            else                             o_illegal = 1'b1;
          end
        endcase
      end
      OP_LUI: begin
        o_regwrite = 1'b1;
        o_alusrc   = 1'b1;
        o_regsel   = RS_LUI;
      end
      OP_SYS: begin
        if (i_funct3 == 3'b001 && i_imm12 == CSR_GPIO_OUT) begin
          o_gpio_we = 1'b1;
        end else if (i_funct3 == 3'b001 && i_imm12 == CSR_GPIO_IN) begin
          o_regwrite = 1'b1;
          o_regsel   = RS_GPIO;
        end else begin
          o_illegal = 1'b1;
        end
      end
      OP_JAL: begin
        o_jal      = 1'b1;
        o_regwrite = 1'b1;
        o_regsel   = RS_PC4;
        o_alusrc   = 1'b1;
      end
      OP_JALR: begin
        if (i_funct3 == 3'b000) begin
          o_jalr     = 1'b1;
          o_regwrite = 1'b1;
          o_regsel   = RS_PC4;
          o_alusrc   = 1'b1;
        end else begin
          o_illegal = 1'b1;
        end
      end
      OP_BR: begin
        o_branch = 1'b1;
        case (i_funct3)
          3'b000, 3'b001: o_aluop = ALU_SUB;
          3'b100, 3'b101: o_aluop = ALU_SLT;
          3'b110, 3'b111: o_aluop = ALU_SLTU;
          default:        o_illegal = 1'b1;
        endcase
      end
      default: o_illegal = 1'b1;
    endcase
    if (o_illegal) begin
      o_regwrite = 1'b0;
      o_gpio_we  = 1'b0;
      o_jal      = 1'b0;
      o_jalr     = 1'b0;
      o_branch   = 1'b0;
`ifdef CTRL_MULDIV_EN
      o_is_div   = 1'b0;
`endif
    end
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// EX-stage control: holds the EX instruction, decodes it, resolves jal/jalr/branch
// redirects with a one-cycle flush. CTRL_MULDIV_EN adds multi-cycle div/rem sequencing.
module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DIV_LATENCY = 8,
  parameter int unsigned ALUOP_W     = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        instr_F,
  input  logic [XLEN-1:0]    R_EX,
  output logic [ALUOP_W-1:0] aluop,
  output logic               alusrc,
  output logic [1:0]         regsel,
  output logic               regwrite,
  output logic               gpio_we,
  output logic [4:0]         rd,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic [11:0]        imm_i,
  output logic [19:0]        imm_u,
  output logic [6:0]         opcode,
  output logic [1:0]         pcsrc_EX,
  output logic               stall_FETCH,
  output logic               flush,
  output logic               illegal_EX,
  output logic               busy
);

  logic [INSTR_W-1:0] r_ir_ex;
  aluop_e             w_aluop;
  regsel_e            w_regsel;
  logic               w_alusrc;
  logic               w_dec_regwrite;
  logic               w_gpio_we;
  logic               w_jal;
  logic               w_jalr;
  logic               w_branch;
  logic               w_illegal;
  logic               w_br_taken;
  logic               w_redirect;
  logic               w_run;
  logic               w_hold;
  logic               w_div_stall;
  logic               w_div_block;
  logic               w_busy;
  logic [2:0]         w_funct3;

  assign w_funct3 = r_ir_ex[14:12];

`ifdef CTRL_MULDIV_EN
  logic w_is_div;
`endif

  instructionDecoder u_dec (
`ifdef CTRL_MULDIV_EN
    .o_is_div   (w_is_div),
`endif
    .i_opcode   (r_ir_ex[6:0]),
    .i_funct3   (r_ir_ex[14:12]),
    .i_imm12    (r_ir_ex[31:20]),
    .o_aluop    (w_aluop),
    .o_alusrc   (w_alusrc),
    .o_regsel   (w_regsel),
    .o_regwrite (w_dec_regwrite),
    .o_gpio_we  (w_gpio_we),
    .o_jal      (w_jal),
    .o_jalr     (w_jalr),
    .o_branch   (w_branch),
    .o_illegal  (w_illegal)
  );

  // Branch condition from the EX ALU result (sub for eq/ne, slt/sltu for the rest).
  always_comb begin
    w_br_taken = 1'b0;
    case (w_funct3)
      3'b000:         w_br_taken = (R_EX == '0);
      3'b001:         w_br_taken = (R_EX != '0);
      3'b100, 3'b110: w_br_taken = (R_EX == XLEN'(1));
      3'b101, 3'b111: w_br_taken = (R_EX == '0);
      default:        w_br_taken = 1'b0;
    endcase
  end

  assign w_redirect = w_run & (w_jal | w_jalr | (w_branch & w_br_taken));

  // Next-PC select; only meaningful while running.
  always_comb begin
    pcsrc_EX = PC_PLUS4;
    if (w_run) begin
      if (w_jalr)                      pcsrc_EX = PC_JALR;
      else if (w_jal)                  pcsrc_EX = PC_JAL;
      else if (w_branch && w_br_taken) pcsrc_EX = PC_BRANCH;
    end
  end

`ifdef CTRL_MULDIV_EN
  state_e                r_state;
  state_e                w_state_nxt;
  logic [DIV_CNT_W-1:0]  r_cnt;
  logic [DIV_CNT_W-1:0]  w_cnt_nxt;

  // Divide sequencer state and countdown registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Divide sequencing: EX is frozen until the final cycle, which performs the writeback.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hold      = 1'b0;
    w_div_stall = 1'b0;
    w_div_block = 1'b0;
    w_busy      = 1'b0;
    w_run       = (r_state == ST_RUN);
    case (r_state)
      ST_RUN: begin
        if (w_is_div && (DIV_LATENCY > 1)) begin
          w_state_nxt = ST_DIV_BUSY;
          w_cnt_nxt   = DIV_CNT_W'(DIV_LATENCY - 2);
          w_hold      = 1'b1;
          w_div_stall = 1'b1;
          w_div_block = 1'b1;
          w_busy      = 1'b1;
        end
      end
      default: begin
        w_busy = 1'b1;
        if (r_cnt != '0) begin
          w_cnt_nxt   = r_cnt - DIV_CNT_W'(1);
          w_hold      = 1'b1;
          w_div_stall = 1'b1;
          w_div_block = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
    endcase
  end
`else
  assign w_run       = 1'b1;
  assign w_hold      = 1'b0;
  assign w_div_stall = 1'b0;
  assign w_div_block = 1'b0;
  assign w_busy      = 1'b0;
`endif

  // EX instruction register: hold during divide, NOP on redirect, else take fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_ir_ex <= NOP;
    else if (w_hold)     r_ir_ex <= r_ir_ex;
    else if (w_redirect) r_ir_ex <= NOP;
    else                 r_ir_ex <= instr_F;
  end

  assign aluop       = ALUOP_W'(w_aluop);
  assign alusrc      = w_alusrc;
  assign regsel      = w_regsel;
  assign regwrite    = w_dec_regwrite & ~w_div_block;
  assign gpio_we     = w_gpio_we;
  assign illegal_EX  = w_illegal;
  assign stall_FETCH = w_redirect | w_div_stall;
  assign flush       = w_redirect;
  assign busy        = w_busy;
  assign rd          = r_ir_ex[11:7];
  assign rs1         = r_ir_ex[19:15];
  assign rs2         = r_ir_ex[24:20];
  assign imm_i       = r_ir_ex[31:20];
  assign imm_u       = r_ir_ex[31:12];
  assign opcode      = r_ir_ex[6:0];

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: directed scenarios plus a randomized
// instruction stream checked against a cycle-level behavioural model.
module tb_pipe_ctrl_unit;

  localparam int unsigned DL    = 8;
  localparam logic [31:0] NOP_I = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_F;
  logic [31:0] R_EX;
  logic [4:0]  aluop;
  logic        alusrc;
  logic [1:0]  regsel;
  logic        regwrite;
  logic        gpio_we;
  logic [4:0]  rd, rs1, rs2;
  logic [11:0] imm_i;
  logic [19:0] imm_u;
  logic [6:0]  opcode;
  logic [1:0]  pcsrc_EX;
  logic        stall_FETCH;
  logic        flush;
  logic        illegal_EX;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.XLEN(32), .DIV_LATENCY(DL), .ALUOP_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .instr_F(instr_F), .R_EX(R_EX),
    .aluop(aluop), .alusrc(alusrc), .regsel(regsel), .regwrite(regwrite),
    .gpio_we(gpio_we), .rd(rd), .rs1(rs1), .rs2(rs2), .imm_i(imm_i),
    .imm_u(imm_u), .opcode(opcode), .pcsrc_EX(pcsrc_EX),
    .stall_FETCH(stall_FETCH), .flush(flush), .illegal_EX(illegal_EX), .busy(busy)
  );

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2,
      input logic [4:0] s1, input logic [2:0] f3, input logic [4:0] d, input logic [6:0] op);
    return {f7, s2, s1, f3, d, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] s1,
      input logic [2:0] f3, input logic [4:0] d, input logic [6:0] op);
    return {imm, s1, f3, d, op};
  endfunction

  // Expected per-instruction behaviour; c_* flags mark fields the decode table defines.
  typedef struct packed {
    logic [4:0] aluop;
    logic       alusrc;
    logic [1:0] regsel;
    logic       regwrite;
    logic       gpio_we;
    logic [1:0] pcsrc;
    logic       illegal;
    logic       is_div;
    logic       c_aluop;
    logic       c_alusrc;
    logic       c_regsel;
    logic       c_regwrite;
  } exp_t;

  localparam logic [4:0] R_FN [8] = '{5'd3, 5'd8, 5'd12, 5'd13, 5'd2, 5'd9, 5'd1, 5'd0};
  localparam logic [4:0] I_FN [8] = '{5'd3, 5'd8, 5'd12, 5'd13, 5'd2, 5'd9, 5'd1, 5'd0};

  function automatic exp_t alu_op(input logic [4:0] op, input logic src);
    exp_t e;
    e = '0;
    e.aluop = op; e.alusrc = src; e.regsel = 2'b10; e.regwrite = 1'b1;
    e.c_aluop = 1'b1; e.c_alusrc = 1'b1; e.c_regsel = 1'b1; e.c_regwrite = 1'b1;
    return e;
  endfunction

  function automatic exp_t ref_dec(input logic [31:0] ir, input logic [31:0] r);
    exp_t e;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [11:0] imm;
    logic tk;
    op = ir[6:0]; f3 = ir[14:12]; f7 = ir[31:25]; imm = ir[31:20];
    e = '0; e.illegal = 1'b1; e.c_regwrite = 1'b1;
    if (op == 7'h33 && f7 == 7'h00) e = alu_op(R_FN[f3], 1'b0);
    else if (op == 7'h33 && f7 == 7'h20 && f3 == 3'd0) e = alu_op(5'd4, 1'b0);
    else if (op == 7'h33 && f7 == 7'h20 && f3 == 3'd5) e = alu_op(5'd10, 1'b0);
    else if (op == 7'h33 && f7 == 7'h01 && f3 == 3'd0) e = alu_op(5'd5, 1'b0);
    else if (op == 7'h33 && f7 == 7'h01 && f3 == 3'd1) e = alu_op(5'd6, 1'b0);
    else if (op == 7'h33 && f7 == 7'h01 && f3 == 3'd3) e = alu_op(5'd7, 1'b0);
    else if (op == 7'h33 && f7 == 7'h01 && f3 >= 3'd4) begin
`ifdef CTRL_MULDIV_EN
      e = alu_op(5'd16 + 5'(f3 - 3'd4), 1'b0);
      e.is_div = 1'b1;
`endif
    end
    else if (op == 7'h13 && f3 != 3'd1 && f3 != 3'd5) e = alu_op(I_FN[f3], 1'b1);
    else if (op == 7'h13 && f3 == 3'd1 && f7 == 7'h00) e = alu_op(5'd8, 1'b1);
    else if (op == 7'h13 && f3 == 3'd5 && f7 == 7'h00) e = alu_op(5'd9, 1'b1);
    else if (op == 7'h13 && f3 == 3'd5 && f7 == 7'h20) e = alu_op(5'd10, 1'b1);
    else if (op == 7'h37) begin
      e = '0; e.regwrite = 1'b1; e.regsel = 2'b01; e.c_regsel = 1'b1; e.c_regwrite = 1'b1;
    end
    else if (op == 7'h73 && f3 == 3'd1 && imm == 12'hf02) begin
      e = '0; e.gpio_we = 1'b1; e.c_regwrite = 1'b1;
    end
    else if (op == 7'h73 && f3 == 3'd1 && imm == 12'hf00) begin
      e = '0; e.regwrite = 1'b1; e.regsel = 2'b00; e.c_regsel = 1'b1; e.c_regwrite = 1'b1;
    end
    else if (op == 7'h6F) begin
      e = '0; e.pcsrc = 2'b10;
    end
    else if (op == 7'h67 && f3 == 3'd0) begin
      e = alu_op(5'd3, 1'b1); e.regsel = 2'b11; e.pcsrc = 2'b01;
    end
    else if (op == 7'h63 && f3 != 3'd2 && f3 != 3'd3) begin
      e = '0; e.c_aluop = 1'b1; e.c_regwrite = 1'b1;
      e.aluop = (f3 < 3'd2) ? 5'd4 : (f3 < 3'd6) ? 5'd12 : 5'd13;
      case (f3)
        3'd0:       tk = (r == 0);
        3'd1:       tk = (r != 0);
        3'd4, 3'd6: tk = (r == 1);
        default:    tk = (r == 0);
      endcase
      e.pcsrc = tk ? 2'b11 : 2'b00;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] d, s1, s2;
    logic [2:0] f3;
    logic [31:0] w;
    d = 5'($urandom); s1 = 5'($urandom); s2 = 5'($urandom); f3 = 3'($urandom);
    w = 32'($urandom);
    case ($urandom_range(0, 11))
      0: return enc_r(7'h00, s2, s1, f3, d, 7'h33);
      1: return enc_r(7'h20, s2, s1, ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd5, d, 7'h33);
      2: begin
        if (f3 == 3'd2) f3 = 3'd3;
        return enc_r(7'h01, s2, s1, f3, d, 7'h33);
      end
      3, 4: begin
        if (f3 == 3'd1) return enc_r(7'h00, s2, s1, f3, d, 7'h13);
        if (f3 == 3'd5) return enc_r(($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20, s2, s1, f3, d, 7'h13);
        return enc_i(w[11:0], s1, f3, d, 7'h13);
      end
      5: return {w[19:0], d, 7'h37};
      6: return enc_i(($urandom_range(0, 1) == 0) ? 12'hf00 : 12'hf02, s1, 3'd1, d, 7'h73);
      7: return {w[19:0], d, 7'h6F};
      8: return enc_i(w[11:0], s1, 3'd0, d, 7'h67);
      9, 10: return {w[6:0], s2, s1, f3, w[11:7], 7'h63};
      default: begin
        case ($urandom_range(0, 3))
          0:       return {w[31:7], 7'h03};
          1:       return {w[31:7], 7'h23};
          2:       return {w[31:7], 7'h0B};
          default: return {w[31:7], 7'h00};
        endcase
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr_F = NOP_I; R_EX = '0;
    #12;
    n_cmp++; if (regwrite !== 1'b1) begin n_fail++; $display("FAIL rst_regwrite got=%b exp=1", regwrite); end
    n_cmp++; if (aluop !== 5'b00011) begin n_fail++; $display("FAIL rst_aluop got=%b exp=00011", aluop); end
    n_cmp++; if (alusrc !== 1'b1 || regsel !== 2'b10) begin n_fail++; $display("FAIL rst_src_sel got=%b/%b exp=1/10", alusrc, regsel); end
    n_cmp++; if ({gpio_we, pcsrc_EX, stall_FETCH, flush, illegal_EX, busy} !== 7'b0) begin
      n_fail++; $display("FAIL rst_ctrl got=%b exp=0000000", {gpio_we, pcsrc_EX, stall_FETCH, flush, illegal_EX, busy}); end
    n_cmp++; if (opcode !== 7'h13 || rd !== 5'd0) begin n_fail++; $display("FAIL rst_ir got=%h/%0d exp=13/0", opcode, rd); end
  endtask

  task automatic test_addi();
    instr_F = enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13);
    @(negedge clk); rst_n = 1'b1;
    tick(); #2;
    n_cmp++; if (regwrite !== 1'b1 || aluop !== 5'b00011) begin n_fail++; $display("FAIL addi_wr_op got=%b/%b exp=1/00011", regwrite, aluop); end
    n_cmp++; if (rd !== 5'd1 || imm_i !== 12'd5) begin n_fail++; $display("FAIL addi_fields got=%0d/%0d exp=1/5", rd, imm_i); end
    n_cmp++; if (stall_FETCH !== 1'b0 || alusrc !== 1'b1) begin n_fail++; $display("FAIL addi_stall_src got=%b/%b exp=0/1", stall_FETCH, alusrc); end
  endtask

  task automatic test_branch();
    instr_F = {7'b0, 5'd2, 5'd1, 3'b000, 5'b0, 7'h63};
    tick();
    instr_F = enc_i(12'd7, 5'd0, 3'd0, 5'd5, 7'h13);
    R_EX = 32'd0; #2;
    n_cmp++; if (pcsrc_EX !== 2'b11 || stall_FETCH !== 1'b1 || flush !== 1'b1) begin
      n_fail++; $display("FAIL beq_taken got=%b/%b/%b exp=11/1/1", pcsrc_EX, stall_FETCH, flush); end
    n_cmp++; if (aluop !== 5'b00100 || regwrite !== 1'b0) begin n_fail++; $display("FAIL beq_dec got=%b/%b exp=00100/0", aluop, regwrite); end
    tick(); #2;
    n_cmp++; if (opcode !== 7'h13 || rd !== 5'd0 || imm_i !== 12'd0) begin
      n_fail++; $display("FAIL beq_flush got=%h/%0d/%0d exp=13/0/0", opcode, rd, imm_i); end
    instr_F = {7'b0, 5'd2, 5'd1, 3'b000, 5'b0, 7'h63};
    tick();
    instr_F = enc_i(12'd7, 5'd0, 3'd0, 5'd5, 7'h13);
    R_EX = 32'd5; #2;
    n_cmp++; if (pcsrc_EX !== 2'b00 || flush !== 1'b0 || stall_FETCH !== 1'b0) begin
      n_fail++; $display("FAIL beq_not_taken got=%b/%b/%b exp=00/0/0", pcsrc_EX, flush, stall_FETCH); end
    tick(); #2;
    n_cmp++; if (rd !== 5'd5 || regwrite !== 1'b1) begin n_fail++; $display("FAIL beq_fallthru got=%0d/%b exp=5/1", rd, regwrite); end
  endtask

  task automatic test_jalr();
    instr_F = enc_i(12'd0, 5'd2, 3'd0, 5'd1, 7'h67);
    tick();
    instr_F = enc_i(12'd9, 5'd0, 3'd0, 5'd6, 7'h13); #2;
    n_cmp++; if (pcsrc_EX !== 2'b01 || regsel !== 2'b11 || regwrite !== 1'b1) begin
      n_fail++; $display("FAIL jalr_dec got=%b/%b/%b exp=01/11/1", pcsrc_EX, regsel, regwrite); end
    n_cmp++; if (flush !== 1'b1 || stall_FETCH !== 1'b1 || aluop !== 5'b00011 || alusrc !== 1'b1) begin
      n_fail++; $display("FAIL jalr_ctl got=%b/%b/%b/%b exp=1/1/00011/1", flush, stall_FETCH, aluop, alusrc); end
    tick(); #2;
    n_cmp++; if (opcode !== 7'h13 || rd !== 5'd0) begin n_fail++; $display("FAIL jalr_flush got=%h/%0d exp=13/0", opcode, rd); end
  endtask

  task automatic test_div();
    instr_F = enc_r(7'h01, 5'd2, 5'd1, 3'b100, 5'd3, 7'h33);
    tick();
    instr_F = enc_i(12'd1, 5'd0, 3'd0, 5'd7, 7'h13);
`ifdef CTRL_MULDIV_EN
    for (int c = 1; c <= int'(DL); c++) begin
      #2;
      n_cmp++;
      if (stall_FETCH !== (c < int'(DL)) || regwrite !== (c == int'(DL)) || busy !== 1'b1 || rd !== 5'd3) begin
        n_fail++;
        $display("FAIL div_cycle c=%0d got stall=%b wr=%b busy=%b rd=%0d exp stall=%b wr=%b busy=1 rd=3",
                 c, stall_FETCH, regwrite, busy, rd, c < int'(DL), c == int'(DL));
      end
      tick();
    end
    #2;
    n_cmp++; if (rd !== 5'd7 || busy !== 1'b0) begin n_fail++; $display("FAIL div_next got=%0d/%b exp=7/0", rd, busy); end
`else
    #2;
    n_cmp++; if (illegal_EX !== 1'b1 || regwrite !== 1'b0 || stall_FETCH !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL div_illegal got=%b/%b/%b/%b exp=1/0/0/0", illegal_EX, regwrite, stall_FETCH, busy); end
    tick(); #2;
    n_cmp++; if (rd !== 5'd7 || illegal_EX !== 1'b0) begin n_fail++; $display("FAIL div_next got=%0d/%b exp=7/0", rd, illegal_EX); end
`endif
  endtask

  task automatic test_reset_mid_div();
`ifdef CTRL_MULDIV_EN
    instr_F = enc_r(7'h01, 5'd2, 5'd1, 3'b110, 5'd3, 7'h33);
    tick();
    instr_F = enc_i(12'd1, 5'd0, 3'd0, 5'd7, 7'h13);
    tick(); tick(); tick(); #2;
    n_cmp++; if (busy !== 1'b1 || regwrite !== 1'b0) begin n_fail++; $display("FAIL rstdiv_pre got=%b/%b exp=1/0", busy, regwrite); end
    rst_n = 1'b0; #1;
    n_cmp++; if (busy !== 1'b0 || regwrite !== 1'b1 || stall_FETCH !== 1'b0 || opcode !== 7'h13 || rd !== 5'd0) begin
      n_fail++; $display("FAIL rstdiv_post got=%b/%b/%b/%h/%0d exp=0/1/0/13/0", busy, regwrite, stall_FETCH, opcode, rd); end
    @(negedge clk); rst_n = 1'b1;
    tick(); #2;
    n_cmp++; if (rd !== 5'd7 || regwrite !== 1'b1 || stall_FETCH !== 1'b0) begin
      n_fail++; $display("FAIL rstdiv_resume got=%0d/%b/%b exp=7/1/0", rd, regwrite, stall_FETCH); end
`endif
  endtask

  task automatic test_csr();
    instr_F = enc_i(12'hf02, 5'd1, 3'd1, 5'd0, 7'h73);
    tick();
    instr_F = enc_i(12'hf00, 5'd0, 3'd1, 5'd5, 7'h73); #2;
    n_cmp++; if (gpio_we !== 1'b1 || regwrite !== 1'b0) begin n_fail++; $display("FAIL csr_f02 got=%b/%b exp=1/0", gpio_we, regwrite); end
    tick(); #2;
    n_cmp++; if (gpio_we !== 1'b0 || regwrite !== 1'b1 || regsel !== 2'b00) begin
      n_fail++; $display("FAIL csr_f00 got=%b/%b/%b exp=0/1/00", gpio_we, regwrite, regsel); end
  endtask

  // Random stream: model tracks the EX instruction and how long a divide has occupied EX.
  task automatic test_random();
    logic [31:0] m_ir;
    int          m_age;
    exp_t        e;
    logic        div_multi, occ, x_stall, x_flush, x_wr;
    @(negedge clk); rst_n = 1'b0; #1; rst_n = 1'b1;
    m_ir = NOP_I; m_age = 1;
    for (int n = 0; n < 600; n++) begin
      instr_F = rand_instr();
      case ($urandom_range(0, 3))
        0:       R_EX = 32'd0;
        1:       R_EX = 32'd1;
        2:       R_EX = 32'd5;
        default: R_EX = $urandom;
      endcase
      #2;
      e = ref_dec(m_ir, R_EX);
      div_multi = e.is_div && (DL > 1);
      occ       = div_multi && (m_age < int'(DL));
      x_flush   = (e.pcsrc != 2'b00);
      x_stall   = x_flush || occ;
      x_wr      = e.regwrite && !occ;
      n_cmp++;
      if (illegal_EX !== e.illegal || gpio_we !== e.gpio_we || pcsrc_EX !== e.pcsrc) begin
        n_fail++; $display("FAIL rnd_ctl n=%0d ir=%h got=%b/%b/%b exp=%b/%b/%b", n, m_ir,
                           illegal_EX, gpio_we, pcsrc_EX, e.illegal, e.gpio_we, e.pcsrc);
      end
      n_cmp++;
      if (stall_FETCH !== x_stall || flush !== x_flush || busy !== div_multi) begin
        n_fail++; $display("FAIL rnd_pipe n=%0d ir=%h got=%b/%b/%b exp=%b/%b/%b", n, m_ir,
                           stall_FETCH, flush, busy, x_stall, x_flush, div_multi);
      end
      if (e.c_regwrite) begin
        n_cmp++;
        if (regwrite !== x_wr) begin n_fail++; $display("FAIL rnd_regwrite n=%0d ir=%h got=%b exp=%b", n, m_ir, regwrite, x_wr); end
      end
      if (e.c_aluop) begin
        n_cmp++;
        if (aluop !== e.aluop) begin n_fail++; $display("FAIL rnd_aluop n=%0d ir=%h got=%b exp=%b", n, m_ir, aluop, e.aluop); end
      end
      if (e.c_alusrc) begin
        n_cmp++;
        if (alusrc !== e.alusrc) begin n_fail++; $display("FAIL rnd_alusrc n=%0d ir=%h got=%b exp=%b", n, m_ir, alusrc, e.alusrc); end
      end
      if (e.c_regsel) begin
        n_cmp++;
        if (regsel !== e.regsel) begin n_fail++; $display("FAIL rnd_regsel n=%0d ir=%h got=%b exp=%b", n, m_ir, regsel, e.regsel); end
      end
      n_cmp++;
      if ({rd, rs1, rs2, imm_i, imm_u, opcode} !== {m_ir[11:7], m_ir[19:15], m_ir[24:20], m_ir[31:20], m_ir[31:12], m_ir[6:0]}) begin
        n_fail++; $display("FAIL rnd_fields n=%0d got rd=%0d rs1=%0d rs2=%0d op=%h exp ir=%h", n, rd, rs1, rs2, opcode, m_ir);
      end
      @(posedge clk); #1;
      if (occ) m_age++;
      else begin
        m_ir  = x_flush ? NOP_I : instr_F;
        m_age = 1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_branch();
    test_jalr();
    test_div();
    test_reset_mid_div();
    test_csr();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
